// File: rtl/cache_mem_arbiter.sv
// Shares one cache-to-bridge memory port between icache (I) and dcache (D) reads; dcache writes pass straight through.
// Latency: read request/grant is combinational (0 cycles); return beats are routed combinationally to the owning port.
// Backpressure: the losing or waiting port sees rd_rdy=0 until the read FSM is back in IDLE; the write path mirrors wr_rdy.
module cache_mem_arbiter #(
   parameter int LINE_BYTES = 16,
   parameter int ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   // icache read port
   input  logic                    i_rd_req,
   input  logic [2:0]              i_rd_type,
   input  logic [ADDR_W-1:0]       i_rd_addr,
   output logic                    i_rd_rdy,
   output logic                    i_ret_valid,
   output logic                    i_ret_last,
   output logic [31:0]             i_ret_data,
   // dcache read port
   input  logic                    d_rd_req,
   input  logic [2:0]              d_rd_type,
   input  logic [ADDR_W-1:0]       d_rd_addr,
   output logic                    d_rd_rdy,
   output logic                    d_ret_valid,
   output logic                    d_ret_last,
   output logic [31:0]             d_ret_data,
   // dcache write port
   input  logic                    d_wr_req,
   input  logic [2:0]              d_wr_type,
   input  logic [ADDR_W-1:0]       d_wr_addr,
   input  logic [3:0]              d_wr_wstrb,
   input  logic [LINE_BYTES*8-1:0] d_wr_data,
   output logic                    d_wr_rdy,
   // memory side
   output logic                    rd_req,
   output logic [2:0]              rd_type,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic                    rd_rdy,
   input  logic                    ret_valid,
   input  logic                    ret_last,
   input  logic [31:0]             ret_data,
   output logic                    wr_req,
   output logic [2:0]              wr_type,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [3:0]              wr_wstrb,
   output logic [LINE_BYTES*8-1:0] wr_data,
   input  logic                    wr_rdy,
   output logic                    err
);

   localparam int BEATS = LINE_BYTES / 4;
   // One extra bit so a legal burst never wraps the counter.
   localparam int CW    = $clog2(BEATS) + 1;

   typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

   state_t        state, state_nxt;
   logic          prio_d;      // 1: D wins a tie, 0: I wins a tie
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] exp_beats;
   logic          err_q;

   logic          idle;
   logic          any_req;
   logic          win_d;
   logic          accept;
   logic [2:0]    win_type;
   logic [CW-1:0] exp_sel;
   logic [CW-1:0] cnt_inc;

   // Winner selection and beat bookkeeping helpers.
   always_comb begin
      idle     = (state == IDLE);
      any_req  = i_rd_req | d_rd_req;
      win_d    = d_rd_req & (~i_rd_req | prio_d);
      win_type = win_d ? d_rd_type : i_rd_type;
      accept   = idle & any_req & rd_rdy;
      exp_sel  = (win_type == 3'b100) ? CW'(BEATS) : CW'(1);
      cnt_inc  = beat_cnt + 1'b1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: lock the winner on accept, release on its last beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:         if (accept) state_nxt = win_d ? OWN_D : OWN_I;
         OWN_I, OWN_D: if (ret_valid && ret_last) state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   // Round-robin priority, expected burst length, beat counter and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_d    <= 1'b1;
         beat_cnt  <= '0;
         exp_beats <= CW'(1);
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            exp_beats <= exp_sel;
            prio_d    <= ~win_d;
            beat_cnt  <= '0;
         end
         if (ret_valid) begin
            if (idle) begin
               // Beat with no owner: dropped, flagged.
               err_q <= 1'b1;
            end else begin
               beat_cnt <= ret_last ? '0 : cnt_inc;
               if (ret_last && (cnt_inc != exp_beats))  err_q <= 1'b1;
               if (!ret_last && (cnt_inc == exp_beats)) err_q <= 1'b1;
            end
         end
      end
   end

   // Outputs: grant/route by state, everything read-side held at 0 in reset.
   always_comb begin
      rd_req      = ~reset & idle & any_req;
      rd_type     = rd_req ? win_type : 3'b000;
      rd_addr     = rd_req ? (win_d ? d_rd_addr : i_rd_addr) : '0;
      i_rd_rdy    = rd_req & rd_rdy & ~win_d;
      d_rd_rdy    = rd_req & rd_rdy & win_d;
      i_ret_valid = ~reset & (state == OWN_I) & ret_valid;
      i_ret_last  = ~reset & (state == OWN_I) & ret_last;
      d_ret_valid = ~reset & (state == OWN_D) & ret_valid;
      d_ret_last  = ~reset & (state == OWN_D) & ret_last;
      i_ret_data  = reset ? 32'h0 : ret_data;
      d_ret_data  = reset ? 32'h0 : ret_data;
      err         = ~reset & err_q;
      wr_req      = d_wr_req;
      wr_type     = d_wr_type;
      wr_addr     = d_wr_addr;
      wr_wstrb    = d_wr_wstrb;
      wr_data     = d_wr_data;
      d_wr_rdy    = wr_rdy;
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grant order, beat routing, error flag, reset and write pass-through.
// Inputs change 1 time unit after posedge; outputs are sampled 1-3 units later, before the next edge.
// Each comparison goes through chk(); the run ends with one summary line.
module tb_cache_mem_arbiter;

   localparam int LB = 16;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            i_rd_req, d_rd_req;
   logic [2:0]      i_rd_type, d_rd_type;
   logic [AW-1:0]   i_rd_addr, d_rd_addr;
   logic            i_rd_rdy, d_rd_rdy;
   logic            i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
   logic [31:0]     i_ret_data, d_ret_data;
   logic            d_wr_req;
   logic [2:0]      d_wr_type;
   logic [AW-1:0]   d_wr_addr;
   logic [3:0]      d_wr_wstrb;
   logic [LB*8-1:0] d_wr_data;
   logic            d_wr_rdy;
   logic            rd_req;
   logic [2:0]      rd_type;
   logic [AW-1:0]   rd_addr;
   logic            rd_rdy, ret_valid, ret_last;
   logic [31:0]     ret_data;
   logic            wr_req;
   logic [2:0]      wr_type;
   logic [AW-1:0]   wr_addr;
   logic [3:0]      wr_wstrb;
   logic [LB*8-1:0] wr_data;
   logic            wr_rdy;
   logic            err;

   int n_chk = 0;
   int n_err = 0;

   cache_mem_arbiter #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
      .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
      .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
      .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
      .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
      .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
      .wr_data(wr_data), .wr_rdy(wr_rdy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   localparam logic [AW-1:0] I_ADDR  = 32'h1000_0000;
   localparam logic [AW-1:0] D_ADDR  = 32'h2000_0000;
   localparam logic [127:0]  W_DATA  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

   initial begin
      reset = 1'b1;
      i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
      d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
      d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
      rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;

      // Reset: read side silent even with live inputs; write side passes through.
      nxt();
      i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1c00_0040; rd_rdy = 1;
      ret_valid = 1; ret_data = 32'h55;
      d_wr_req = 1; wr_rdy = 1;
      #1;
      chk("rst_rd_req", rd_req, 0);
      chk("rst_i_rdy", i_rd_rdy, 0);
      chk("rst_i_ret_valid", i_ret_valid, 0);
      chk("rst_d_ret_valid", d_ret_valid, 0);
      chk("rst_i_ret_data", i_ret_data, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_req", wr_req, 1);
      chk("rst_d_wr_rdy", d_wr_rdy, 1);

      // Test 1: icache line read, granted in the request cycle, 4 beats.
      nxt();
      reset = 0; ret_valid = 0; d_wr_req = 0; wr_rdy = 0;
      #1;
      chk("t1_rd_req", rd_req, 1);
      chk("t1_rd_addr", rd_addr, 32'h1c00_0040);
      chk("t1_rd_type", rd_type, 3'b100);
      chk("t1_i_rdy", i_rd_rdy, 1);
      chk("t1_d_rdy", d_rd_rdy, 0);
      nxt();
      i_rd_req = 0;
      for (int k = 0; k < 4; k++) begin
         ret_valid = 1; ret_data = 32'hA0 + k; ret_last = (k == 3);
         #1;
         chk("t1_i_ret_valid", i_ret_valid, 1);
         chk("t1_i_ret_data", i_ret_data, 32'hA0 + k);
         chk("t1_i_ret_last", i_ret_last, (k == 3));
         chk("t1_d_ret_valid", d_ret_valid, 0);
         nxt();
      end
      ret_valid = 0; ret_last = 0;

      // Test 2: simultaneous requests, D wins first.
      i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = I_ADDR;
      d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = D_ADDR;
      #1;
      chk("t1_err", err, 0);
      chk("t2_rd_addr_d", rd_addr, D_ADDR);
      chk("t2_d_rdy", d_rd_rdy, 1);
      chk("t2_i_rdy_lose", i_rd_rdy, 0);
      nxt();
      d_rd_req = 0;
      for (int k = 0; k < 4; k++) begin
         ret_valid = 1; ret_data = 32'hB0 + k; ret_last = (k == 3);
         #1;
         chk("t2_d_ret_valid", d_ret_valid, 1);
         chk("t2_d_ret_data", d_ret_data, 32'hB0 + k);
         chk("t2_i_ret_valid", i_ret_valid, 0);
         chk("t2_i_rdy_wait", i_rd_rdy, 0);
         chk("t2_rd_req_own", rd_req, 0);
         nxt();
      end
      ret_valid = 0; ret_last = 0;
      #1;
      chk("t2_i_grant", i_rd_rdy, 1);
      chk("t2_rd_addr_i", rd_addr, I_ADDR);
      nxt();
      i_rd_req = 0;
      for (int k = 0; k < 4; k++) begin
         ret_valid = 1; ret_data = 32'hC0 + k; ret_last = (k == 3);
         #1;
         chk("t2_i_ret_valid", i_ret_valid, 1);
         chk("t2_d_ret_valid_i", d_ret_valid, 0);
         nxt();
      end
      ret_valid = 0; ret_last = 0;
      // Third pair: D again; its request is the uncached word read of test 3.
      i_rd_req = 1;
      d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'hbfaf_8000;
      #1;
      chk("t2_third_d_rdy", d_rd_rdy, 1);
      chk("t2_third_i_rdy", i_rd_rdy, 0);
      chk("t3_rd_addr", rd_addr, 32'hbfaf_8000);
      chk("t3_rd_type", rd_type, 3'b010);
      nxt();

      // Test 3: single beat with ret_last.
      d_rd_req = 0;
      ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
      #1;
      chk("t3_d_ret_valid", d_ret_valid, 1);
      chk("t3_d_ret_last", d_ret_last, 1);
      chk("t3_d_ret_data", d_ret_data, 32'hDEAD_BEEF);
      chk("t3_i_ret_valid", i_ret_valid, 0);
      chk("t3_i_rdy_last", i_rd_rdy, 0);
      nxt();
      ret_valid = 0; ret_last = 0;

      // Test 4: I held while memory is not ready.
      rd_rdy = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_rd_req", rd_req, 1);
         chk("t4_rd_addr", rd_addr, I_ADDR);
         chk("t4_i_rdy", i_rd_rdy, 0);
         nxt();
      end
      rd_rdy = 1;
      #1;
      chk("t4_grant", i_rd_rdy, 1);
      nxt();

      // Test 5a: line read cut short by ret_last on beat 2.
      i_rd_req = 0;
      ret_valid = 1; ret_last = 0; ret_data = 32'hE0;
      #1;
      chk("t5_beat1", i_ret_valid, 1);
      nxt();
      ret_last = 1; ret_data = 32'hE1;
      #1;
      chk("t5_beat2_last", i_ret_last, 1);
      chk("t5_err_before", err, 0);
      nxt();
      ret_valid = 0; ret_last = 0;
      d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h4000_0000; rd_rdy = 0;
      #1;
      chk("t5_short_err", err, 1);
      chk("t5_idle_rd_req", rd_req, 1);
      chk("t5_idle_rd_addr", rd_addr, 32'h4000_0000);
      nxt();
      reset = 1; d_rd_req = 0;
      nxt();
      reset = 0;
      #1;
      chk("t5_err_cleared", err, 0);
      // Test 5b: spurious beat in IDLE.
      ret_valid = 1; ret_data = 32'h77;
      #1;
      chk("t5_spur_i", i_ret_valid, 0);
      chk("t5_spur_d", d_ret_valid, 0);
      nxt();
      ret_valid = 0;
      #1;
      chk("t5_spur_err", err, 1);

      // Test 6: reset during an OWN_D burst, plus a write alongside the burst.
      nxt();
      reset = 1;
      nxt();
      reset = 0;
      d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h3000_0000; rd_rdy = 1;
      #1;
      chk("t6_d_grant", d_rd_rdy, 1);
      nxt();
      d_rd_req = 0;
      ret_valid = 1; ret_data = 32'hF0;
      d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h3000_0100;
      d_wr_wstrb = 4'hF; d_wr_data = W_DATA; wr_rdy = 1;
      #1;
      chk("t6_beat1", d_ret_valid, 1);
      chk("t6_wr_req", wr_req, 1);
      chk("t6_wr_data", wr_data, W_DATA);
      chk("t6_wr_addr", wr_addr, 32'h3000_0100);
      chk("t6_wr_wstrb", wr_wstrb, 4'hF);
      chk("t6_d_wr_rdy", d_wr_rdy, 1);
      nxt();
      reset = 1; ret_data = 32'hF1; d_wr_req = 0; wr_rdy = 0; d_rd_req = 1;
      #1;
      chk("t6_rst_d_ret_valid", d_ret_valid, 0);
      chk("t6_rst_d_rdy", d_rd_rdy, 0);
      chk("t6_rst_rd_req", rd_req, 0);
      chk("t6_rst_i_ret_valid", i_ret_valid, 0);
      chk("t6_rst_d_ret_data", d_ret_data, 0);
      chk("t6_wr_req_off", wr_req, 0);
      nxt();
      reset = 0; rd_rdy = 0; ret_data = 32'hF2;
      #1;
      chk("t6_leftover_dropped", d_ret_valid, 0);
      chk("t6_idle_rd_req", rd_req, 1);
      nxt();
      ret_valid = 0; d_rd_req = 0;
      #1;
      chk("t6_leftover_err", err, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
